// File: rtl/linked_list_builder.sv
// -----------------------------------------------------------------------------
// linked_list_builder
//
// Builds and maintains a singly linked list in a node memory of 2**ADDR_WIDTH
// words. Each word is {data, next}, with next in the low ADDR_WIDTH bits.
// Unused nodes sit on an internal free list. Push takes the free-list head and
// links it in front of the list head. Pop unlinks the head node and returns
// it to the free list. The tail node is marked by a self-loop (next == own
// address).
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst          asynchronous, active-low reset
//   i_push_valid   push request
//   i_push_data    payload for the new head node
//   o_push_ready   push accepted when i_push_valid && o_push_ready
//   i_pop_valid    request to remove the head node
//   o_pop_ready    pop accepted when i_pop_valid && o_pop_ready
//   o_pop_data     payload of the removed node (registered, held)
//   o_pop_done     one-cycle pulse, o_pop_data valid in this cycle
//   o_head_node    address of the current head node
//   o_list_empty   high when o_count == 0
//   o_count        number of nodes in the list
//   o_init_done    high once the free list is built
//   i_rd_addr      node read address for the downstream walker
//   o_rd_node      combinational read of mem[i_rd_addr]
//   o_state        FSM state (0 = INIT, 1 = IDLE), for observation
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Ready never depends on the same channel's valid. Push ready does
// depend on pop valid, because pop has priority and the two never complete in
// the same cycle.
// -----------------------------------------------------------------------------
module linked_list_builder #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_push_valid,
    input  logic [DATA_WIDTH-1:0]          i_push_data,
    output logic                           o_push_ready,
    input  logic                           i_pop_valid,
    output logic                           o_pop_ready,
    output logic [DATA_WIDTH-1:0]          o_pop_data,
    output logic                           o_pop_done,
    output logic [ADDR_WIDTH-1:0]          o_head_node,
    output logic                           o_list_empty,
    output logic [ADDR_WIDTH:0]            o_count,
    output logic                           o_init_done,
    input  logic [ADDR_WIDTH-1:0]          i_rd_addr,
    output logic [DATA_WIDTH+ADDR_WIDTH-1:0] o_rd_node,
    output logic                           o_state
);

    localparam int NODES = 2 ** ADDR_WIDTH;
    localparam int WORD  = DATA_WIDTH + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = NODES[ADDR_WIDTH:0];

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [WORD-1:0]       r_mem [NODES];
    logic [ADDR_WIDTH-1:0] r_init_ptr;
    logic [ADDR_WIDTH-1:0] r_head;
    logic [ADDR_WIDTH-1:0] r_free;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_pop_data;
    logic                  r_pop_done;
    logic                  r_init_done;

    logic                  w_empty;
    logic                  w_push_ready;
    logic                  w_pop_ready;
    logic                  w_push_fire;
    logic                  w_pop_fire;
    logic                  w_init_last;
    logic [WORD-1:0]       w_head_word;
    logic [WORD-1:0]       w_free_word;

    assign w_empty     = (r_count == '0);
    assign w_push_fire = i_push_valid && w_push_ready;
    assign w_pop_fire  = i_pop_valid && w_pop_ready;
    assign w_init_last = (r_init_ptr == {ADDR_WIDTH{1'b1}});
    assign w_head_word = r_mem[r_head];
    assign w_free_word = r_mem[r_free];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state and readies ----------------
    always_comb begin
        w_state_next = r_state;
        w_push_ready = 1'b0;
        w_pop_ready  = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (w_init_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                w_pop_ready  = !w_empty;
                // Pop wins: a pending pop request holds off any push.
                w_push_ready = (r_count != FULL_COUNT) && !i_pop_valid;
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    // ---------------- List bookkeeping registers ----------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_init_ptr  <= '0;
            r_head      <= '0;
            r_free      <= '0;
            r_count     <= '0;
            r_pop_data  <= '0;
            r_pop_done  <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_pop_done <= 1'b0;
            if (r_state == ST_INIT) begin
                r_init_ptr <= r_init_ptr + 1'b1;
                if (w_init_last) begin
                    r_init_done <= 1'b1;
                end
            end else if (w_pop_fire) begin
                r_pop_data <= w_head_word[WORD-1:ADDR_WIDTH];
                r_pop_done <= 1'b1;
                // Last node self-loops, so force the head back to 0 explicitly.
                r_head     <= (r_count == 1) ? '0 : w_head_word[ADDR_WIDTH-1:0];
                r_free     <= r_head;
                r_count    <= r_count - 1'b1;
            end else if (w_push_fire) begin
                r_free  <= w_free_word[ADDR_WIDTH-1:0];
                r_head  <= r_free;
                r_count <= r_count + 1'b1;
            end
        end
    end

    // ---------------- Node memory (not cleared by reset) ----------------
    // INIT chains every node to its successor, the last entry wrapping to 0.
    always_ff @(posedge i_clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_init_ptr] <= {{DATA_WIDTH{1'b0}}, r_init_ptr + 1'b1};
        end else if (w_pop_fire) begin
            r_mem[r_head][ADDR_WIDTH-1:0] <= r_free;
        end else if (w_push_fire) begin
            // First node into an empty list points at itself to mark the tail.
            r_mem[r_free] <= {i_push_data, (w_empty ? r_free : r_head)};
        end
    end

    assign o_push_ready = w_push_ready;
    assign o_pop_ready  = w_pop_ready;
    assign o_pop_data   = r_pop_data;
    assign o_pop_done   = r_pop_done;
    assign o_head_node  = r_head;
    assign o_list_empty = w_empty;
    assign o_count      = r_count;
    assign o_init_done  = r_init_done;
    assign o_rd_node    = r_mem[i_rd_addr];
    assign o_state      = r_state;

endmodule

// File: tb/tb_linked_list_builder.sv
// -----------------------------------------------------------------------------
// tb_linked_list_builder
//
// Directed bench for linked_list_builder with default parameters (16 nodes,
// 4-bit data). Inputs are driven 1 time unit after each rising edge. Outputs
// are sampled at that point too, and combinational readies are sampled one
// more unit later, once the inputs have settled.
// -----------------------------------------------------------------------------
module tb_linked_list_builder;

    localparam int AW = 4;
    localparam int DW = 4;

    logic          clk;
    logic          rst;
    logic          push_valid;
    logic [DW-1:0] push_data;
    logic          push_ready;
    logic          pop_valid;
    logic          pop_ready;
    logic [DW-1:0] pop_data;
    logic          pop_done;
    logic [AW-1:0] head_node;
    logic          list_empty;
    logic [AW:0]   count;
    logic          init_done;
    logic [AW-1:0] rd_addr;
    logic [DW+AW-1:0] rd_node;
    logic          state;

    int n_checks = 0;
    int n_errors = 0;

    linked_list_builder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_push_valid (push_valid),
        .i_push_data  (push_data),
        .o_push_ready (push_ready),
        .i_pop_valid  (pop_valid),
        .o_pop_ready  (pop_ready),
        .o_pop_data   (pop_data),
        .o_pop_done   (pop_done),
        .o_head_node  (head_node),
        .o_list_empty (list_empty),
        .o_count      (count),
        .o_init_done  (init_done),
        .i_rd_addr    (rd_addr),
        .o_rd_node    (rd_node),
        .o_state      (state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Payload pushed in the fill phase for the i-th push.
    function automatic logic [DW-1:0] fd(input int i);
        return DW'(i * 3 + 1);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst        = 1'b0;
        push_valid = 1'b0;
        push_data  = '0;
        pop_valid  = 1'b0;
        rd_addr    = '0;

        // Reset state
        #12;
        chk("rst_count", count, 0);
        chk("rst_head", head_node, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_pop_done", pop_done, 0);
        chk("rst_state", state, 0);

        // Init: 15 edges without init_done, 16th raises it
        tick();
        rst = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("init_busy_done", init_done, 0);
            chk("init_busy_push_ready", push_ready, 0);
        end
        tick();
        chk("init_done", init_done, 1);
        chk("init_push_ready", push_ready, 1);
        chk("init_pop_ready", pop_ready, 0);
        chk("init_count", count, 0);
        chk("init_empty", list_empty, 1);
        chk("init_state", state, 1);
        rd_addr = 4'd3;
        #1 chk("init_mem3", rd_node, 8'h04);
        rd_addr = 4'd15;
        #1 chk("init_mem15_wrap", rd_node, 8'h00);

        // Push A, B, C
        push_valid = 1'b1;
        push_data = 4'hA; tick();
        push_data = 4'hB; tick();
        push_data = 4'hC; tick();
        push_valid = 1'b0;
        chk("abc_count", count, 3);
        chk("abc_head", head_node, 2);
        rd_addr = 4'd2; #1 chk("abc_node2", rd_node, 8'hC1);
        rd_addr = 4'd1; #1 chk("abc_node1", rd_node, 8'hB0);
        rd_addr = 4'd0; #1 chk("abc_node0_tail", rd_node, 8'hA0);

        // Three back-to-back pops
        pop_valid = 1'b1;
        #1 chk("abc_push_ready_blocked", push_ready, 0);
        tick();
        chk("pop1_done", pop_done, 1);
        chk("pop1_data", pop_data, 4'hC);
        tick();
        chk("pop2_done", pop_done, 1);
        chk("pop2_data", pop_data, 4'hB);
        tick();
        chk("pop3_done", pop_done, 1);
        chk("pop3_data", pop_data, 4'hA);
        chk("pop3_empty", list_empty, 1);
        chk("pop3_pop_ready", pop_ready, 0);
        tick();
        chk("pop_empty_ignored_done", pop_done, 0);
        chk("pop_empty_ignored_count", count, 0);
        chk("pop_data_held", pop_data, 4'hA);
        pop_valid = 1'b0;

        // Fill all 16 nodes; free list hands out addresses 0..15 in order
        push_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push_data = fd(i);
            tick();
        end
        chk("full_count", count, 16);
        chk("full_head", head_node, 15);
        chk("full_push_ready", push_ready, 0);
        push_data = 4'h5;
        tick();
        chk("full_17th_held_count", count, 16);
        chk("full_17th_held_head", head_node, 15);
        rd_addr = 4'd15;
        #1 chk("full_node15", rd_node, {fd(15), 4'd14});
        push_valid = 1'b0;

        // One pop frees node 15, next push reuses it
        pop_valid = 1'b1;
        tick();
        pop_valid = 1'b0;
        chk("free_pop_data", pop_data, fd(15));
        chk("free_pop_count", count, 15);
        chk("free_pop_head", head_node, 14);
        #1 chk("free_push_ready", push_ready, 1);
        push_valid = 1'b1;
        push_data = 4'h7;
        tick();
        push_valid = 1'b0;
        chk("reuse_head", head_node, 15);
        chk("reuse_count", count, 16);
        rd_addr = 4'd15;
        #1 chk("reuse_node15", rd_node, 8'h7E);

        // Pop 14 nodes (15 down to 2), leaving nodes 1 -> 0
        pop_valid = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        pop_valid = 1'b0;
        chk("drain_last_data", pop_data, fd(2));
        chk("drain_count", count, 2);
        chk("drain_head", head_node, 1);

        // Simultaneous push and pop: pop wins, push completes next cycle
        pop_valid  = 1'b1;
        push_valid = 1'b1;
        push_data  = 4'h9;
        #1 chk("both_push_ready", push_ready, 0);
        chk("both_pop_ready", pop_ready, 1);
        tick();
        pop_valid = 1'b0;
        chk("both_count_after_pop", count, 1);
        chk("both_pop_data", pop_data, fd(1));
        chk("both_head_after_pop", head_node, 0);
        #1 chk("both_push_ready_next", push_ready, 1);
        tick();
        push_valid = 1'b0;
        chk("both_count_after_push", count, 2);
        chk("both_head_after_push", head_node, 1);
        rd_addr = 4'd1;
        #1 chk("both_node1", rd_node, 8'h90);

        // Grow to 6 nodes, pop once to leave 5 with pop_done high
        push_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_data = 4'(i + 2);
            tick();
        end
        push_valid = 1'b0;
        chk("pre_rst_count6", count, 6);
        pop_valid = 1'b1;
        tick();
        pop_valid = 1'b0;
        chk("pre_rst_count5", count, 5);
        chk("pre_rst_pop_done", pop_done, 1);
        chk("pre_rst_pop_data", pop_data, 4'h5);

        // Asynchronous reset mid-cycle
        #2 rst = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_head", head_node, 0);
        chk("arst_pop_done", pop_done, 0);
        chk("arst_pop_data", pop_data, 0);
        chk("arst_init_done", init_done, 0);
        chk("arst_pop_ready", pop_ready, 0);
        chk("arst_push_ready", push_ready, 0);
        tick();
        rst = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("reinit_busy_done", init_done, 0);
        end
        tick();
        chk("reinit_done", init_done, 1);
        chk("reinit_count", count, 0);
        chk("reinit_empty", list_empty, 1);
        rd_addr = 4'd1;
        #1 chk("reinit_mem1", rd_node, 8'h02);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Safety net against a stalled run
    initial begin
        #20000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
